// File: rtl/firmware_loader.sv
// Receives a framed firmware image byte-by-byte and writes it into the firmware/vector stores.
// Optional inter-byte timeout is enabled with the FIRMWARE_LOADER_TIMEOUT_EN macro.
module firmware_loader #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic        boot_from_rom,
  output logic [13:0] wr_address,
  output logic [7:0]  wr_data,
  output logic        wr_en_firmware,
  output logic        wr_en_vectors,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE
  } state_t;

  localparam logic [7:0]  MAGIC   = 8'hA5;
  localparam logic [15:0] MAX_LEN = 16'h2006;
  localparam logic [13:0] FW_SIZE = 14'h2000;

  state_t      state_reg;
  logic [7:0]  len_lo_reg;
  logic [13:0] len_reg;
  logic [13:0] index_reg;
  logic [7:0]  sum_reg;

  logic        take;
  logic [15:0] len_full;
  logic [7:0]  sum_next;
  logic        timeout_hit;
  logic        loaded;

  assign take     = rx_valid && rx_ready;
  assign len_full = {rx_data, len_lo_reg};
  assign sum_next = sum_reg + rx_data;

`ifdef FIRMWARE_LOADER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt_reg;
  logic             loaded_reg;
  logic             in_frame;

  assign in_frame    = (state_reg == S_LEN_LO) || (state_reg == S_LEN_HI) ||
                       (state_reg == S_DATA)   || (state_reg == S_CSUM);
  assign timeout_hit = in_frame && !take && (idle_cnt_reg == CNT_LAST);
  assign loaded      = loaded_reg;

  // Counts consecutive byte-less cycles while a frame is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_reg <= '0;
    end else if (!in_frame || take || timeout_hit) begin
      idle_cnt_reg <= '0;
    end else begin
      idle_cnt_reg <= idle_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded_reg <= 1'b0;
    end else if (state_reg == S_CSUM && take && sum_next == 8'h00) begin
      loaded_reg <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign loaded      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      len_lo_reg     <= '0;
      len_reg        <= '0;
      index_reg      <= '0;
      sum_reg        <= '0;
      rx_ready       <= 1'b0;
      wr_address     <= '0;
      wr_data        <= '0;
      wr_en_firmware <= 1'b0;
      wr_en_vectors  <= 1'b0;
      cpu_hold       <= 1'b1;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      rx_ready       <= 1'b1;
      wr_en_firmware <= 1'b0;
      wr_en_vectors  <= 1'b0;
      if (timeout_hit) begin
        error <= 1'b1;
        if (loaded) begin
          state_reg <= S_DONE;
          done      <= 1'b1;
          cpu_hold  <= 1'b0;
        end else begin
          state_reg <= S_IDLE;
        end
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (take && rx_data == MAGIC) begin
              state_reg <= S_LEN_LO;
              error     <= 1'b0;
            end else if (boot_from_rom) begin
              state_reg <= S_DONE;
              done      <= 1'b1;
              cpu_hold  <= 1'b0;
            end
          end
          S_LEN_LO: begin
            if (take) begin
              len_lo_reg <= rx_data;
              state_reg  <= S_LEN_HI;
            end
          end
          S_LEN_HI: begin
            if (take) begin
              if (len_full == 16'h0000 || len_full > MAX_LEN) begin
                error     <= 1'b1;
                state_reg <= S_IDLE;
              end else begin
                len_reg   <= len_full[13:0];
                index_reg <= '0;
                sum_reg   <= '0;
                state_reg <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (take) begin
              wr_data <= rx_data;
              // Indices past the firmware window land in the 6-entry vector store.
              if (index_reg < FW_SIZE) begin
                wr_en_firmware <= 1'b1;
                wr_address     <= index_reg;
              end else begin
                wr_en_vectors <= 1'b1;
                wr_address    <= index_reg - FW_SIZE;
              end
              sum_reg   <= sum_next;
              index_reg <= index_reg + 1'b1;
              if (index_reg == len_reg - 1'b1) begin
                state_reg <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (take) begin
              if (sum_next == 8'h00) begin
                state_reg <= S_DONE;
                done      <= 1'b1;
                cpu_hold  <= 1'b0;
              end else begin
                error     <= 1'b1;
                state_reg <= S_IDLE;
              end
            end
          end
          S_DONE: begin
            if (take && rx_data == MAGIC) begin
              state_reg <= S_LEN_LO;
              cpu_hold  <= 1'b1;
              done      <= 1'b0;
              error     <= 1'b0;
            end
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule
